mpsoc_dbg_syncflop_array: RTL and testbench

//  Multi-channel toggle-event synchroniser for the debug interface: CHANNELS independent toggle inputs from a

---
 rtl/mpsoc_dbg_syncflop_array_pkg.sv | 14 +
 rtl/mpsoc_dbg_syncflop_array_if.sv | 25 ++
 rtl/mpsoc_dbg_syncflop_array_sync_chain.sv | 29 ++
 rtl/mpsoc_dbg_syncflop_array.sv | 96 +++++++++
 tb/tb_mpsoc_dbg_syncflop_array.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mpsoc_dbg_syncflop_array_pkg.sv
// Shared constants and helpers for the debug toggle-event synchroniser.
// Holds the minimum synchroniser depth and the saturating overrun increment.
package mpsoc_dbg_sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    function automatic int unsigned ovr_sat_inc(
        input int unsigned cur,
        input int unsigned max_val
    );
        return (cur >= max_val) ? cur : cur + 1;
    endfunction

endpackage

// File: rtl/mpsoc_dbg_syncflop_array_if.sv
// Signal bundle for the multi-channel toggle-event synchroniser.
// master drives the requests, slave is the synchroniser side.
interface mpsoc_dbg_syncflop_array_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
);
    logic [CHANNELS-1:0]       TOGGLE_IN;
    logic [CHANNELS-1:0]       D_SET;
    logic [CHANNELS-1:0]       D_RST;
    logic [CHANNELS-1:0]       IRQ_MASK;
    logic [CHANNELS-1:0]       D_OUT;
    logic [CHANNELS-1:0]       OVERRUN;
    logic [CHANNELS*CNT_W-1:0] OVR_CNT;
    logic                      IRQ;

    modport master (
        output TOGGLE_IN, D_SET, D_RST, IRQ_MASK,
        input  D_OUT, OVERRUN, OVR_CNT, IRQ
    );

    modport slave (
        input  TOGGLE_IN, D_SET, D_RST, IRQ_MASK,
        output D_OUT, OVERRUN, OVR_CNT, IRQ
    );
endinterface

// File: rtl/mpsoc_dbg_syncflop_array_sync_chain.sv
// Single-bit asynchronous-reset synchroniser chain of SYNC_STAGES flops.
module mpsoc_dbg_sync_chain
    import mpsoc_dbg_sync_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_depth
        $error("mpsoc_dbg_sync_chain: SYNC_STAGES too small");
    end

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/mpsoc_dbg_syncflop_array.sv
// Multi-channel toggle-event synchroniser with sticky flags and overrun counters.
// Define MPSOC_DBG_SYNCFLOP_IRQ_EN to build the registered, masked event interrupt.
module mpsoc_dbg_syncflop_array
    import mpsoc_dbg_sync_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                      DEST_CLK,
    input  logic                      RESET,
    input  logic [CHANNELS-1:0]       TOGGLE_IN,
    input  logic [CHANNELS-1:0]       D_SET,
    input  logic [CHANNELS-1:0]       D_RST,
    input  logic [CHANNELS-1:0]       IRQ_MASK,
    output logic [CHANNELS-1:0]       D_OUT,
    output logic [CHANNELS-1:0]       OVERRUN,
    output logic [CHANNELS*CNT_W-1:0] OVR_CNT,
    output logic                      IRQ
);

    localparam int unsigned CNT_MAX = 32'((64'(1) << CNT_W) - 64'(1));

    logic [CHANNELS-1:0]            w_sync;
    logic [CHANNELS-1:0]            w_toggle;
    logic [CHANNELS-1:0]            r_prev;
    logic [CHANNELS-1:0]            r_flag;
    logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        mpsoc_dbg_sync_chain #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk (DEST_CLK),
            .i_rst (RESET),
            .i_d   (TOGGLE_IN[g]),
            .o_q   (w_sync[g])
        );
    end

    assign w_toggle = w_sync ^ r_prev;

    // Counter looks at the flag before this edge; clear beats everything.
    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            r_prev <= '0;
            r_flag <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_sync;
            for (int i = 0; i < CHANNELS; i++) begin
                if (D_RST[i]) begin
                    r_flag[i] <= 1'b0;
                    r_cnt[i]  <= '0;
                end else begin
                    if (w_toggle[i] && r_flag[i]) begin
                        r_cnt[i] <= CNT_W'(ovr_sat_inc(32'(r_cnt[i]), CNT_MAX));
                    end
                    if (w_toggle[i] || D_SET[i]) begin
                        r_flag[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        OVERRUN = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            OVERRUN[i] = |r_cnt[i];
        end
    end

    assign D_OUT   = w_toggle | r_flag;
    assign OVR_CNT = r_cnt;

`ifdef MPSOC_DBG_SYNCFLOP_IRQ_EN
    logic r_irq;

    always_ff @(posedge DEST_CLK or posedge RESET) begin
        if (RESET) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(w_toggle & IRQ_MASK);
        end
    end

    assign IRQ = r_irq;
`else
    logic w_unused_irq_mask;

    assign w_unused_irq_mask = |IRQ_MASK;
    assign IRQ               = 1'b0;
`endif

endmodule

// File: tb/tb_mpsoc_dbg_syncflop_array.sv
// Randomised bench for mpsoc_dbg_syncflop_array against a sample-history model.
module tb_mpsoc_dbg_syncflop_array;

    localparam int CH = 4;
    localparam int SS = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpsoc_dbg_syncflop_array_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    mpsoc_dbg_syncflop_array #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .CNT_W       (CW)
    ) dut (
        .DEST_CLK  (clk),
        .RESET     (rst),
        .TOGGLE_IN (bus.TOGGLE_IN),
        .D_SET     (bus.D_SET),
        .D_RST     (bus.D_RST),
        .IRQ_MASK  (bus.IRQ_MASK),
        .D_OUT     (bus.D_OUT),
        .OVERRUN   (bus.OVERRUN),
        .OVR_CNT   (bus.OVR_CNT),
        .IRQ       (bus.IRQ)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // q[0] is the most recent TOGGLE_IN sample taken at a clock edge.
    logic [CH-1:0] mq[$];
    logic [CH-1:0] mflag;
    int            mcnt[CH];
    logic          mirq;

    function automatic logic [CH-1:0] mev();
        return mq[SS-1] ^ mq[SS];
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        repeat (SS + 1) mq.push_back('0);
        mflag = '0;
        for (int i = 0; i < CH; i++) mcnt[i] = 0;
        mirq = 1'b0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] ev;
        ev = mev();
        for (int i = 0; i < CH; i++) begin
            if (bus.D_RST[i]) begin
                mflag[i] = 1'b0;
                mcnt[i]  = 0;
            end else begin
                if (ev[i] && mflag[i] && mcnt[i] < CMAX) mcnt[i]++;
                if (ev[i] || bus.D_SET[i]) mflag[i] = 1'b1;
            end
        end
`ifdef MPSOC_DBG_SYNCFLOP_IRQ_EN
        mirq = |(ev & bus.IRQ_MASK);
`else
        mirq = 1'b0;
`endif
        mq.push_front(bus.TOGGLE_IN);
        void'(mq.pop_back());
    endtask

    task automatic compare();
        logic [CH-1:0]    ovr;
        logic [CH*CW-1:0] pk;
        for (int i = 0; i < CH; i++) begin
            ovr[i] = (mcnt[i] != 0);
            pk[i*CW +: CW] = CW'(mcnt[i]);
        end
        chk("d_out", 32'(bus.D_OUT), 32'(mev() | mflag));
        chk("overrun", 32'(bus.OVERRUN), 32'(ovr));
        chk("ovr_cnt", 32'(bus.OVR_CNT), 32'(pk));
        chk("irq", 32'(bus.IRQ), 32'(mirq));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        logic [CH*CW-1:0] v;
        v = bus.OVR_CNT;
        return v[ch*CW +: CW];
    endfunction

    int irq_seen;
    int last[CH];
    logic [CH-1:0] v;

    initial begin
        bus.TOGGLE_IN = '1;
        bus.D_SET     = '0;
        bus.D_RST     = '0;
        bus.IRQ_MASK  = '0;
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_dout", 32'(bus.D_OUT), 32'h0);
        chk("rst_ovr", 32'(bus.OVERRUN), 32'h0);
        chk("rst_cnt", 32'(bus.OVR_CNT), 32'h0);
        tick();
        tick();
        bus.TOGGLE_IN = '0;
        rst = 1'b0;
        repeat (5) tick();
        chk("rel_dout", 32'(bus.D_OUT), 32'h0);

        // latency on channel 0
        bus.TOGGLE_IN[0] = 1'b1;
        tick();
        tick();
        chk("lat_e2", 32'(bus.D_OUT[0]), 32'h0);
        tick();
        chk("lat_e3", 32'(bus.D_OUT[0]), 32'h1);
        repeat (3) tick();
        chk("lat_hold", 32'(bus.D_OUT[0]), 32'h1);
        bus.D_RST[0] = 1'b1;
        tick();
        bus.D_RST[0] = 1'b0;
        chk("lat_clr", 32'(bus.D_OUT[0]), 32'h0);

        // event coinciding with clear on channel 1
        bus.TOGGLE_IN[1] = 1'b1;
        repeat (3) tick();
        chk("pri_ev", 32'(bus.D_OUT[1]), 32'h1);
        bus.D_RST[1] = 1'b1;
        tick();
        bus.D_RST[1] = 1'b0;
        chk("pri_dout", 32'(bus.D_OUT[1]), 32'h0);
        chk("pri_cnt", 32'(cnt_of(1)), 32'h0);

        // saturating overrun on channel 2
        bus.TOGGLE_IN[2] = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 17; k++) begin
            bus.TOGGLE_IN[2] = ~bus.TOGGLE_IN[2];
            repeat (4) tick();
            if (k == 0) chk("ovr_first", 32'(cnt_of(2)), 32'h1);
        end
        chk("ovr_sat", 32'(cnt_of(2)), 32'hF);
        chk("ovr_flag", 32'(bus.OVERRUN[2]), 32'h1);
        bus.D_RST[2] = 1'b1;
        tick();
        bus.D_RST[2] = 1'b0;
        chk("ovr_clr", 32'(cnt_of(2)), 32'h0);
        chk("ovr_clr_f", 32'(bus.OVERRUN[2]), 32'h0);

        // software set on channel 3
        bus.D_SET[3] = 1'b1;
        tick();
        bus.D_SET[3] = 1'b0;
        chk("dset_out", 32'(bus.D_OUT[3]), 32'h1);
        chk("dset_cnt", 32'(cnt_of(3)), 32'h0);

        // interrupt merging and masking
        bus.IRQ_MASK = 4'b0101;
        bus.TOGGLE_IN[0] = ~bus.TOGGLE_IN[0];
        bus.TOGGLE_IN[2] = ~bus.TOGGLE_IN[2];
        irq_seen = 0;
        repeat (6) begin
            tick();
            if (bus.IRQ) irq_seen++;
        end
`ifdef MPSOC_DBG_SYNCFLOP_IRQ_EN
        chk("irq_single", 32'(irq_seen), 32'h1);
`else
        chk("irq_off", 32'(irq_seen), 32'h0);
`endif
        bus.TOGGLE_IN[1] = ~bus.TOGGLE_IN[1];
        irq_seen = 0;
        repeat (6) begin
            tick();
            if (bus.IRQ) irq_seen++;
        end
        chk("irq_masked", 32'(irq_seen), 32'h0);

        // randomised phase, rate limit respected per channel
        for (int i = 0; i < CH; i++) last[i] = cyc;
        for (int n = 0; n < 600; n++) begin
            v = bus.TOGGLE_IN;
            for (int i = 0; i < CH; i++) begin
                if (cyc - last[i] >= SS + 1 && $urandom_range(0, 3) == 0) begin
                    v[i] = ~v[i];
                    last[i] = cyc;
                end
                bus.D_SET[i] = ($urandom_range(0, 9) == 0);
                bus.D_RST[i] = ($urandom_range(0, 15) == 0);
            end
            bus.TOGGLE_IN = v;
            if (n % 50 == 0) bus.IRQ_MASK = CH'($urandom);
            if (n == 300) begin
                rst = 1'b1;
                model_reset();
                tick();
                chk("midrst_dout", 32'(bus.D_OUT), 32'h0);
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
